// File: rtl/spi_host_cfg_wr_arb.sv
// Round-robin write arbiter for a shared SPI host config register; writes are staged and committed
// only while no SPI transaction is in progress. Optional lock feature: SPI_HOST_CFG_LOCK_EN.
module spi_host_cfg_wr_arb #(
    parameter int unsigned      NumReq     = 2,
    parameter int unsigned      Width      = 8,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NumReq-1:0]       req_i,
    input  logic [NumReq*Width-1:0] wdata_i,
    input  logic                    busy_i,
`ifdef SPI_HOST_CFG_LOCK_EN
    input  logic                    lock_i,
    output logic                    err_o,
`endif
    output logic [NumReq-1:0]       gnt_o,
    output logic [Width-1:0]        q_o,
    output logic                    pend_o,
    output logic                    upd_o
);

    localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef enum logic [0:0] {StIdle, StPend} state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [Width-1:0]  stage_q, stage_d;
    logic [Width-1:0]  cfg_q, cfg_d;
    logic              upd_q, upd_d;

    logic [NumReq-1:0] gnt;
    logic [PtrW-1:0]   gnt_idx;
    logic [PtrW-1:0]   ptr_nxt;
    logic [Width-1:0]  gnt_wdata;
    logic              found;
    logic              hs;
    logic              drop;
    int unsigned       cand;

    // Search from ptr upward with an explicit modulo-NumReq wrap.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        if (state_q == StIdle) begin
            for (int unsigned i = 0; i < NumReq; i++) begin
                cand = 32'(ptr_q) + i;
                if (cand >= NumReq) cand = cand - NumReq;
                for (int unsigned k = 0; k < NumReq; k++) begin
                    if (!found && (k == cand) && req_i[k]) begin
                        gnt[k]  = 1'b1;
                        gnt_idx = PtrW'(k);
                        found   = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        gnt_wdata = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (gnt[k]) gnt_wdata = wdata_i[k*Width +: Width];
        end
    end

    assign hs      = |gnt;
    assign ptr_nxt = (gnt_idx == PtrW'(NumReq - 1)) ? '0 : gnt_idx + PtrW'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        stage_d = stage_q;
        cfg_d   = cfg_q;
        upd_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (hs) begin
                    ptr_d = ptr_nxt;
                    // A locked arbiter still rotates priority but discards the data.
                    if (!drop) begin
                        stage_d = gnt_wdata;
                        state_d = StPend;
                    end
                end
            end
            StPend: begin
                if (!busy_i) begin
                    cfg_d   = stage_q;
                    upd_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            stage_q <= ResetValue;
            cfg_q   <= ResetValue;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            stage_q <= stage_d;
            cfg_q   <= cfg_d;
            upd_q   <= upd_d;
        end
    end

`ifdef SPI_HOST_CFG_LOCK_EN
    logic lock_q;
    logic err_q;

    assign drop = lock_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            lock_q <= lock_q | lock_i;
            err_q  <= hs & lock_q;
        end
    end

    assign err_o = err_q;
`else
    assign drop = 1'b0;
`endif

    assign gnt_o  = gnt;
    assign q_o    = cfg_q;
    assign pend_o = (state_q == StPend);
    assign upd_o  = upd_q;

endmodule
